// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives PC / pipeline-register write enables and
// synchronous flushes for load-use stalls, taken-branch flushes (resolved in
// MEM) and whole-pipe freezes while data memory is busy, with a timeout that
// releases a hung memory access.
// Optional feature macro: HAZARD_PERF_CNT_EN enables saturating stall/flush
// performance counters; without it both counters read zero and have no flops.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_Rm,
  input  logic [2:0]       id_Rn,
  input  logic             id_useRm,
  input  logic             id_useRn,
  input  logic             p1_memRead,
  input  logic             p1_R_regWrite,
  input  logic [2:0]       p1_Rd,
  input  logic             p2_branch,
  input  logic             p2_taken,
  input  logic             mem_busy,
  output logic             pcWrite,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMemWait, StAbort} state_t;

  state_t           stateQ, stateD;
  logic [WaitW-1:0] waitCntQ, waitCntD;
  logic             errQ, errD;

  logic loadUse, branchTaken, frozen;

  // Hazard detection; ABORT ignores mem_busy so the pipe can drain.
  always_comb begin
    loadUse     = p1_memRead & p1_R_regWrite &
                  ((id_useRm & (p1_Rd == id_Rm)) | (id_useRn & (p1_Rd == id_Rn)));
    branchTaken = p2_branch & p2_taken;
    frozen      = mem_busy & (stateQ != StAbort);
  end

  // Next-state logic for freeze tracking and timeout.
  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    errD     = errQ;
    unique case (stateQ)
      StRun, StMemWait: begin
        if (mem_busy) begin
          waitCntD = waitCntQ + WaitW'(1);
          if (waitCntQ == WaitLast) begin
            // This is the last allowed frozen cycle.
            stateD = StAbort;
            errD   = 1'b1;
          end else begin
            stateD = StMemWait;
          end
        end else begin
          stateD   = StRun;
          waitCntD = '0;
        end
      end
      StAbort: begin
        if (!mem_busy) begin
          stateD   = StRun;
          waitCntD = '0;
        end
      end
      default: begin
        stateD   = StRun;
        waitCntD = '0;
      end
    endcase
  end

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StRun;
      waitCntQ <= '0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      errQ     <= errD;
    end
  end

  // Per-stage enables/flushes: freeze > branch flush > load-use > normal.
  always_comb begin
    pcWrite      = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if (frozen) begin
        // Hold everything; push a bubble into WB.
        mem_wb_write = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (branchTaken) begin
        pcWrite      = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (loadUse) begin
        // Hold PC and IF/ID, bubble into EX.
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end else begin
        pcWrite      = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end
    end
  end

  assign mem_timeout_err = errQ;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCntQ, flushCntQ;
  logic             stallEv, flushEv;

  // Counted events follow the same priority as the enables.
  always_comb begin
    stallEv = frozen | (~branchTaken & loadUse);
    flushEv = ~frozen & branchTaken;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (stallEv && (stallCntQ != '1)) stallCntQ <= stallCntQ + CNT_W'(1);
      if (flushEv && (flushCntQ != '1)) flushCntQ <= flushCntQ + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven single-cycle hazard
// vectors plus hand-written multi-cycle sequences (freeze, timeout, deferred
// branch, counters, async reset mid-freeze).
module tb_pipe_hazard_ctrl;

  localparam int unsigned MemTimeout = 16;
  localparam int unsigned CntW       = 16;

  // {pcWrite, if_id/id_ex/ex_mem/mem_wb write, if_id/id_ex/ex_mem/mem_wb flush}
  localparam logic [8:0] ExpZero  = 9'b0_0000_0000;
  localparam logic [8:0] ExpNorm  = 9'b1_1111_0000;
  localparam logic [8:0] ExpStall = 9'b0_0111_0100;
  localparam logic [8:0] ExpFlush = 9'b1_1111_1110;
  localparam logic [8:0] ExpFrz   = 9'b0_0001_0001;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      id_Rm, id_Rn, p1_Rd;
  logic            id_useRm, id_useRn, p1_memRead, p1_R_regWrite;
  logic            p2_branch, p2_taken, mem_busy;
  logic            pcWrite, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic            mem_timeout_err;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [8:0]      outs;

  int nChecks = 0;
  int nFail   = 0;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_Rm          (id_Rm),
    .id_Rn          (id_Rn),
    .id_useRm       (id_useRm),
    .id_useRn       (id_useRn),
    .p1_memRead     (p1_memRead),
    .p1_R_regWrite  (p1_R_regWrite),
    .p1_Rd          (p1_Rd),
    .p2_branch      (p2_branch),
    .p2_taken       (p2_taken),
    .mem_busy       (mem_busy),
    .pcWrite        (pcWrite),
    .if_id_write    (if_id_write),
    .id_ex_write    (id_ex_write),
    .ex_mem_write   (ex_mem_write),
    .mem_wb_write   (mem_wb_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .mem_wb_flush   (mem_wb_flush),
    .mem_timeout_err(mem_timeout_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign outs = {pcWrite, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] rm, rn, rd;
    logic       useRm, useRn, memRead, regWrite, branch, taken, busy;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input string nm, input logic [2:0] rm, input logic [2:0] rn,
                              input logic useRm, input logic useRn, input logic memRead,
                              input logic regWrite, input logic [2:0] rd, input logic branch,
                              input logic taken, input logic [8:0] exp);
    vec_t v;
    v.name = nm; v.rm = rm; v.rn = rn; v.useRm = useRm; v.useRn = useRn;
    v.memRead = memRead; v.regWrite = regWrite; v.rd = rd;
    v.branch = branch; v.taken = taken; v.busy = 1'b0; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_Rm = v.rm; id_Rn = v.rn; id_useRm = v.useRm; id_useRn = v.useRn;
    p1_memRead = v.memRead; p1_R_regWrite = v.regWrite; p1_Rd = v.rd;
    p2_branch = v.branch; p2_taken = v.taken; mem_busy = v.busy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t idle, lu, br, all3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk("idle", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ExpNorm);
    lu   = mk("lu",   3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, ExpStall);
    br   = mk("br",   3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, ExpFlush);
    all3 = lu; all3.branch = 1'b1; all3.taken = 1'b1; all3.busy = 1'b1;

    vecs[0]  = mk("normal",        3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ExpNorm);
    vecs[1]  = mk("lu_rm",         3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, ExpStall);
    vecs[2]  = mk("lu_rm_unused",  3'd3, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, ExpNorm);
    vecs[3]  = mk("lu_rn",         3'd2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, ExpStall);
    vecs[4]  = mk("lu_rn_unused",  3'd2, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, ExpNorm);
    vecs[5]  = mk("lu_rd_miss",    3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, ExpNorm);
    vecs[6]  = mk("lu_no_load",    3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, ExpNorm);
    vecs[7]  = mk("lu_no_regwr",   3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, ExpNorm);
    vecs[8]  = mk("br_taken",      3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, ExpFlush);
    vecs[9]  = mk("br_not_taken",  3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, ExpNorm);
    vecs[10] = mk("taken_no_br",   3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, ExpNorm);
    vecs[11] = mk("br_over_lu",    3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, ExpFlush);

    // Reset: outputs must be forced to zero even with every hazard asserted.
    reset = 1'b1;
    drive(all3);
    #3;
    chk("reset_outs", 32'(outs), 32'(ExpZero));
    chk("reset_err", 32'(mem_timeout_err), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(idle);

    // Single-cycle table.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      @(negedge clk);
    end
    // Load-use clears once the load has advanced.
    drive(lu);
    #1 chk("lu_seq_stall", 32'(outs), 32'(ExpStall));
    @(negedge clk);
    drive(idle);
    #1 chk("lu_seq_clear", 32'(outs), 32'(ExpNorm));
    @(negedge clk);

    // Short freeze: 5 busy cycles.
    for (int c = 1; c <= 5; c++) begin
      idle.busy = 1'b1;
      drive(idle);
      #1 chk($sformatf("frz5_c%0d", c), 32'(outs), 32'(ExpFrz));
      @(negedge clk);
    end
    idle.busy = 1'b0;
    drive(idle);
    #1 chk("frz5_release", 32'(outs), 32'(ExpNorm));
    @(negedge clk);
    #1 chk("frz5_run", 32'(outs), 32'(ExpNorm));
    chk("frz5_err", 32'(mem_timeout_err), 32'd0);
    @(negedge clk);

    // Freeze + branch + load-use: freeze wins, branch flushes on release.
    drive(all3);
    #1 chk("combo_frz", 32'(outs), 32'(ExpFrz));
    @(negedge clk);
    all3.busy = 1'b0;
    drive(all3);
    #1 chk("combo_branch", 32'(outs), 32'(ExpFlush));
    @(negedge clk);
    drive(idle);
    #1 chk("combo_after", 32'(outs), 32'(ExpNorm));
    @(negedge clk);

    // Hung access: 20 busy cycles, only 16 frozen.
    for (int c = 1; c <= 20; c++) begin
      idle.busy = 1'b1;
      drive(idle);
      #1;
      chk($sformatf("to_c%0d", c), 32'(outs), 32'(c <= 16 ? ExpFrz : ExpNorm));
      chk($sformatf("to_err_c%0d", c), 32'(mem_timeout_err), 32'(c >= 17));
      @(negedge clk);
    end
    idle.busy = 1'b0;
    drive(idle);
    #1 chk("to_release", 32'(outs), 32'(ExpNorm));
    @(negedge clk);
    // Back in RUN: busy freezes again, error stays set.
    idle.busy = 1'b1;
    drive(idle);
    #1 chk("to_refreeze", 32'(outs), 32'(ExpFrz));
    chk("to_err_sticky", 32'(mem_timeout_err), 32'd1);
    @(negedge clk);
    idle.busy = 1'b0;
    drive(idle);
    @(negedge clk);

    // Counters: fresh reset, then 2 load-use + 3 freeze + 1 branch.
    reset = 1'b1;
    #1 chk("cnt_rst_err", 32'(mem_timeout_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(lu);
    @(negedge clk);
    @(negedge clk);
    idle.busy = 1'b1;
    drive(idle);
    repeat (3) @(negedge clk);
    drive(br);
    @(negedge clk);
    idle.busy = 1'b0;
    drive(idle);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
    chk("flush_cnt", 32'(flush_cnt), 32'd1);
`else
    chk("stall_cnt_off", 32'(stall_cnt), 32'd0);
    chk("flush_cnt_off", 32'(flush_cnt), 32'd0);
`endif
    @(negedge clk);

    // Async reset in the middle of a freeze.
    idle.busy = 1'b1;
    drive(idle);
    @(negedge clk);
    #1 chk("ar_frz", 32'(outs), 32'(ExpFrz));
    #1 reset = 1'b1;
    #1;
    chk("ar_outs", 32'(outs), 32'(ExpZero));
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("ar_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // Wait count restarted: a full MemTimeout frozen cycles again.
    for (int c = 1; c <= 17; c++) begin
      #1 chk($sformatf("ar_c%0d", c), 32'(outs), 32'(c <= 16 ? ExpFrz : ExpNorm));
      @(negedge clk);
    end
    idle.busy = 1'b0;
    drive(idle);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller driving the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It inserts load-use stalls, flushes wrong-path instructions on a taken branch resolved in MEM, and freezes the whole pipe while data memory is busy. A timeout releases a hung memory access. Per-stage enables are combinational from registered state and current hazard inputs.

## Interface
- MEM_TIMEOUT, 16, maximum consecutive frozen cycles per memory access (≥2)
- CNT_W, 16, width of performance counters

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_Rm, id_Rn  in  3  source register indices of instruction in ID
- id_useRm, id_useRn  in  1  instruction in ID actually reads Rm / Rn
- p1_memRead  in  1  instruction in EX (ID/EX output) is a load
- p1_R_regWrite  in  1  instruction in EX writes R file
- p1_Rd  in  3  destination of instruction in EX
- p2_branch  in  1  instruction in MEM is a branch
- p2_taken  in  1  branch condition in MEM is true
- mem_busy  in  1  data memory cannot complete MEM-stage access this cycle
- pcWrite  out  1  PC load enable
- if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  per-stage regWritePipe
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  per-stage pipelineFlush (synchronous clear at next edge)
- mem_timeout_err  out  1  sticky: a memory access exceeded MEM_TIMEOUT
- stall_cnt, flush_cnt  out  CNT_W  performance counters (see Configuration)

## Operation
- States: RUN, MEM_WAIT, ABORT. Reset state RUN; wait_cnt (width $clog2(MEM_TIMEOUT+1)) = 0.
- Priority per cycle: freeze > branch flush > load-use stall > normal.
- Freeze (mem_busy=1 in RUN or MEM_WAIT): pcWrite and all *_write = 0 except mem_wb_write=1 with mem_wb_flush=1 (bubble into WB); other flushes 0. wait_cnt increments.
  - RUN→MEM_WAIT on freeze. MEM_WAIT→RUN when mem_busy=0 (wait_cnt←0; that cycle evaluated as RUN).
  - Freeze with wait_cnt==MEM_TIMEOUT-1: next state ABORT, mem_timeout_err←1. Exactly MEM_TIMEOUT frozen cycles occur.
  - ABORT: mem_busy ignored, pipe runs normally; ABORT→RUN when mem_busy=0, wait_cnt←0.
- Branch flush (p2_branch & p2_taken, not frozen): pcWrite=1, all writes 1, if_id_flush=id_ex_flush=ex_mem_flush=1, mem_wb_flush=0. One cycle; no state change.
- Load-use stall (p1_memRead & p1_R_regWrite & ((id_useRm & p1_Rd==id_Rm) | (id_useRn & p1_Rd==id_Rn)), no freeze/flush): pcWrite=0, if_id_write=0, id_ex_write=1 with id_ex_flush=1, ex_mem_write=mem_wb_write=1. Clears itself next cycle as load advances.
- Normal: pcWrite and all writes 1, all flushes 0.
- Taken branch during freeze: deferred; branch is held in EX/MEM and flushes on the first unfrozen cycle.
- mem_timeout_err cleared only by reset.

## Timing
- All outputs combinational from state, wait_cnt and inputs; zero-cycle latency hazard→enable.
- During reset: pcWrite, all *_write, all *_flush = 0; mem_timeout_err=0; counters=0.
- State, wait_cnt, error and counters update on rising clk; reset mid-freeze returns to RUN immediately.
- Load-use stall costs 1 cycle; taken branch costs 3 wrong-path slots; freeze costs cycles of mem_busy, capped at MEM_TIMEOUT.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments each cycle with freeze or load-use stall; flush_cnt increments each branch-flush cycle; both saturate at 2^CNT_W-1.
- Not defined: stall_cnt and flush_cnt tied to 0, no counter flops.

## Test plan
- Load-use: p1_memRead=1, p1_R_regWrite=1, p1_Rd=3, id_Rm=3, id_useRm=1 -> pcWrite=0, if_id_write=0, id_ex_flush=1 for 1 cycle; same with id_useRm=0 -> no stall.
- Taken branch: p2_branch=1, p2_taken=1 -> if_id/id_ex/ex_mem_flush=1, pcWrite=1 one cycle; p2_taken=0 -> no flush.
- mem_busy high 5 cycles (MEM_TIMEOUT=16) -> 5 frozen cycles with mem_wb_flush=1, state returns RUN, mem_timeout_err=0.
- mem_busy held 20 cycles -> exactly 16 frozen cycles, mem_timeout_err=1, pipe runs cycles 17–20, RUN after release, error stays 1.
- Freeze + taken branch + load-use simultaneous -> freeze wins; after mem_busy drops, branch flush next cycle.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 3 freeze cycles + 1 branch -> stall_cnt=5, flush_cnt=1; async reset mid-freeze -> all outputs 0, counters 0.
